mc_control: RTL and testbench
=============================

Name: mc_control

Overview:
- Multicycle MIPS-subset control unit: the producer side of the ALU's `aluop`/`zero` interface.
- Sequences each instruction through a Moore FSM and drives datapath enables, mux selects and `aluop`.
- Samples `zero` from the ALU for branches.
- Sits between the instruction register fields (`opcode`, `funct`) and the multicycle datapath.

Parameters:
- CNT_W, 32, width of retired-instruction counter `instr_retired`.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- opcode  input  6  IR[31:26], valid from DECODE onward.
- funct  input  6  IR[5:0], valid from DECODE onward.
- zero  input  1  ALU zero flag, same cycle as `aluop`.
- aluop  output  4  ALU operation select.
- alu_src_a  output  1  0=PC, 1=regA.
- alu_src_b  output  2  00=regB, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2.
- pc_src  output  2  00=ALU result, 01=ALUOut register, 10=jump target.
- pc_en  output  1  PC write enable.
- ir_write  output  1  IR load enable.
- iord  output  1  memory address select, 0=PC, 1=ALUOut.
- mem_write  output  1  memory write enable.
- reg_write  output  1  register file write enable.
- reg_dst  output  1  0=rt, 1=rd.
- mem_to_reg  output  1  0=ALUOut, 1=MDR.
- illegal_op  output  1  one-cycle pulse in DECODE on unsupported opcode/funct.
- instr_retired  output  CNT_W  count of completed instructions.

Behaviour:
- State register: 4 bits, clocked on `clk`, async-cleared to FETCH by `reset`.
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPE_EX, RTYPE_WB, BEQ_EX, ADDI_EX, ADDI_WB, JUMP.
- Transitions:
  - FETCH -> DECODE.
  - DECODE on `opcode`:
    - 000000 with legal funct -> RTYPE_EX.
    - 100011 (lw) or 101011 (sw) -> MEMADR.
    - 000100 (beq) -> BEQ_EX.
    - 001000 (addi) -> ADDI_EX.
    - 000010 (j) -> JUMP.
    - anything else -> FETCH with `illegal_op`=1.
  - MEMADR -> MEMRD (lw) or MEMWR (sw).
  - MEMRD -> MEMWB.
  - RTYPE_EX -> RTYPE_WB.
  - ADDI_EX -> ADDI_WB.
  - MEMWB, MEMWR, RTYPE_WB, BEQ_EX, ADDI_WB, JUMP -> FETCH.
- Legal funct: 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x26 xor, 0x27 nor, 0x2A slt. In RTYPE_EX, `aluop` = funct[3:0] (0000, 0010, 0100, 0101, 0110, 0111, 1010).
- Outputs are combinational from state (plus `funct` and `zero` where noted). Default for every output is 0; `aluop` defaults to 0000 (SUM).
  - FETCH: iord=0, alu_src_a=0, alu_src_b=01, pc_src=00, ir_write=1, pc_en=1.
  - DECODE: alu_src_a=0, alu_src_b=11 (branch target into ALUOut).
  - MEMADR, ADDI_EX: alu_src_a=1, alu_src_b=10.
  - MEMRD: iord=1.
  - MEMWB: reg_dst=0, mem_to_reg=1, reg_write=1.
  - MEMWR: iord=1, mem_write=1.
  - RTYPE_EX: alu_src_a=1, alu_src_b=00, aluop=funct[3:0].
  - RTYPE_WB: reg_dst=1, reg_write=1.
  - BEQ_EX: alu_src_a=1, alu_src_b=00, aluop=0010, pc_src=01, pc_en=`zero`.
  - ADDI_WB: reg_dst=0, reg_write=1.
  - JUMP: pc_src=10, pc_en=1.
- Reset:
  - While `reset`=1, pc_en, ir_write, mem_write, reg_write and illegal_op are forced 0.
  - Mux selects and `aluop` take their FETCH values.
  - `instr_retired` resets to 0.
  - Reset mid-instruction aborts it; no further write enables assert, and the instruction is not counted.
- Latency (FETCH to FETCH): lw 5 cycles, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2.
- `instr_retired` increments by 1 on each clock edge leaving MEMWB, MEMWR, RTYPE_WB, BEQ_EX (taken or not), ADDI_WB or JUMP. It wraps modulo 2^CNT_W. Illegal instructions are not counted.
- `opcode`/`funct` are ignored in FETCH. A change on them outside DECODE and RTYPE_EX has no effect.

Optional Feature:
- Macro: MC_CONTROL_BNE_EN.
- Defined: adds opcode 000101 (bne). DECODE -> BNE_EX; outputs as BEQ_EX except pc_en=~`zero`; counted as retired; 3-cycle latency.
- Undefined: 000101 is illegal (pulses `illegal_op`, returns to FETCH). No BNE_EX state exists.

Test Plan:
- Reset asserted asynchronously mid-MEMRD -> state FETCH immediately; enables 0 during reset; `instr_retired`=0; first edge after release gives ir_write=1, pc_en=1.
- R-type: opcode 000000, funct 0x2A -> DECODE, RTYPE_EX with aluop=1010, RTYPE_WB with reg_write=1, reg_dst=1; back in FETCH after 4 cycles; `instr_retired` +1.
- lw (100011) then sw (101011) -> lw: 5 cycles with MEMWB mem_to_reg=1, reg_write=1. sw: 4 cycles with MEMWR mem_write=1, iord=1. Counter +2.
- beq with zero=1 -> pc_en=1, pc_src=01 in BEQ_EX. beq with zero=0 -> pc_en=0. Each takes 3 cycles and increments the counter.
- Illegal cases: opcode 111111, then opcode 000000 with funct 0x08 -> each gives `illegal_op` high exactly one cycle in DECODE, returns to FETCH next edge, no reg_write/mem_write, counter unchanged.
- With CNT_W=3, run 9 addi instructions -> `instr_retired` reads 1 (wrap). With MC_CONTROL_BNE_EN defined, opcode 000101 with zero=0 -> pc_en=1; without it -> `illegal_op` pulse.

Source files
------------

// File: rtl/mc_control.sv
// Multicycle MIPS-subset control unit: Moore FSM driving datapath enables, mux selects and aluop.
// Optional bne support is enabled by defining MC_CONTROL_BNE_EN.
module mc_control #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  output logic [3:0]       aluop,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       pc_src,
  output logic             pc_en,
  output logic             ir_write,
  output logic             iord,
  output logic             mem_write,
  output logic             reg_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             illegal_op,
  output logic [CNT_W-1:0] instr_retired
);

  // state    | meaning
  // FETCH    | IR <= mem[PC], PC <= PC+4
  // DECODE   | branch target into ALUOut, dispatch on opcode
  // MEMADR   | address = regA + imm
  // MEMRD    | load read      MEMWB | load writeback
  // MEMWR    | store write
  // RTYPE_EX | ALU op from funct   RTYPE_WB | write rd
  // BEQ_EX   | compare, PC <= ALUOut if zero (BNE_EX: if not zero)
  // ADDI_EX  | regA + imm    ADDI_WB | write rt
  // JUMP     | PC <= jump target
  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_RTYPE_EX = 4'd6,
    S_RTYPE_WB = 4'd7,
    S_BEQ_EX   = 4'd8,
    S_ADDI_EX  = 4'd9,
    S_ADDI_WB  = 4'd10,
`ifdef MC_CONTROL_BNE_EN
    S_BNE_EX   = 4'd12,
`endif
    S_JUMP     = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
`ifdef MC_CONTROL_BNE_EN
  localparam logic [5:0] OP_BNE   = 6'b000101;
`endif

  state_t            state_q, state_d;
  logic              is_sw_q, is_sw_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              funct_ok, retire, illegal_s;
  logic              pc_en_s, ir_write_s, mem_write_s, reg_write_s;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
      is_sw_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      is_sw_q <= is_sw_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    funct_ok = 1'b0;
    case (funct)
      6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A: funct_ok = 1'b1;
      default: funct_ok = 1'b0;
    endcase
  end

  // lw/sw choice is latched in DECODE so opcode may change afterwards.
  always_comb begin
    state_d   = state_q;
    is_sw_d   = is_sw_q;
    illegal_s = 1'b0;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        is_sw_d = (opcode == OP_SW);
        case (opcode)
          OP_RTYPE: begin
            state_d   = funct_ok ? S_RTYPE_EX : S_FETCH;
            illegal_s = ~funct_ok;
          end
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_BEQ:       state_d = S_BEQ_EX;
          OP_ADDI:      state_d = S_ADDI_EX;
          OP_J:         state_d = S_JUMP;
`ifdef MC_CONTROL_BNE_EN
          OP_BNE:       state_d = S_BNE_EX;
`endif
          default: begin
            state_d   = S_FETCH;
            illegal_s = 1'b1;
          end
        endcase
      end
      S_MEMADR:   state_d = is_sw_q ? S_MEMWR : S_MEMRD;
      S_MEMRD:    state_d = S_MEMWB;
      S_RTYPE_EX: state_d = S_RTYPE_WB;
      S_ADDI_EX:  state_d = S_ADDI_WB;
      default:    state_d = S_FETCH;
    endcase
  end

  always_comb begin
    retire = 1'b0;
    case (state_q)
      S_MEMWB, S_MEMWR, S_RTYPE_WB, S_BEQ_EX, S_ADDI_WB, S_JUMP: retire = 1'b1;
`ifdef MC_CONTROL_BNE_EN
      S_BNE_EX: retire = 1'b1;
`endif
      default: retire = 1'b0;
    endcase
    cnt_d = retire ? cnt_q + {{(CNT_W-1){1'b0}}, 1'b1} : cnt_q;
  end

  always_comb begin
    aluop       = 4'b0000;
    alu_src_a   = 1'b0;
    alu_src_b   = 2'b00;
    pc_src      = 2'b00;
    pc_en_s     = 1'b0;
    ir_write_s  = 1'b0;
    iord        = 1'b0;
    mem_write_s = 1'b0;
    reg_write_s = 1'b0;
    reg_dst     = 1'b0;
    mem_to_reg  = 1'b0;
    case (state_q)
      S_FETCH: begin
        alu_src_b  = 2'b01;
        ir_write_s = 1'b1;
        pc_en_s    = 1'b1;
      end
      S_DECODE: alu_src_b = 2'b11;
      S_MEMADR, S_ADDI_EX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_MEMRD: iord = 1'b1;
      S_MEMWB: begin
        mem_to_reg  = 1'b1;
        reg_write_s = 1'b1;
      end
      S_MEMWR: begin
        iord        = 1'b1;
        mem_write_s = 1'b1;
      end
      S_RTYPE_EX: begin
        alu_src_a = 1'b1;
        aluop     = funct[3:0];
      end
      S_RTYPE_WB: begin
        reg_dst     = 1'b1;
        reg_write_s = 1'b1;
      end
      S_BEQ_EX: begin
        alu_src_a = 1'b1;
        aluop     = 4'b0010;
        pc_src    = 2'b01;
        pc_en_s   = zero;
      end
`ifdef MC_CONTROL_BNE_EN
      S_BNE_EX: begin
        alu_src_a = 1'b1;
        aluop     = 4'b0010;
        pc_src    = 2'b01;
        pc_en_s   = ~zero;
      end
`endif
      S_ADDI_WB: reg_write_s = 1'b1;
      S_JUMP: begin
        pc_src  = 2'b10;
        pc_en_s = 1'b1;
      end
      default: ;
    endcase
  end

  // State is already FETCH during reset; only the write enables need masking.
  assign pc_en         = pc_en_s & ~reset;
  assign ir_write      = ir_write_s & ~reset;
  assign mem_write     = mem_write_s & ~reset;
  assign reg_write     = reg_write_s & ~reset;
  assign illegal_op    = illegal_s & ~reset;
  assign instr_retired = cnt_q;

endmodule

// File: tb/tb_mc_control.sv
// Randomized bench for mc_control: per-instruction output table model, checked every cycle.
// Honours MC_CONTROL_BNE_EN the same way as the design.
module tb_mc_control;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [5:0]  opcode = '0, funct = '0;
  logic        zero = 1'b0;
  logic [3:0]  aluop, aluop3;
  logic        alu_src_a, alu_src_a3;
  logic [1:0]  alu_src_b, alu_src_b3, pc_src, pc_src3;
  logic        pc_en, ir_write, iord, mem_write, reg_write, reg_dst, mem_to_reg, illegal_op;
  logic        pc_en3, ir_write3, iord3, mem_write3, reg_write3, reg_dst3, mem_to_reg3, illegal_op3;
  logic [31:0] instr_retired;
  logic [2:0]  instr_retired3;

  always #5 clk = ~clk;

  mc_control dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .aluop(aluop), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .pc_src(pc_src),
    .pc_en(pc_en), .ir_write(ir_write), .iord(iord), .mem_write(mem_write),
    .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .illegal_op(illegal_op), .instr_retired(instr_retired)
  );

  mc_control #(.CNT_W(3)) dut3 (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .aluop(aluop3), .alu_src_a(alu_src_a3), .alu_src_b(alu_src_b3), .pc_src(pc_src3),
    .pc_en(pc_en3), .ir_write(ir_write3), .iord(iord3), .mem_write(mem_write3),
    .reg_write(reg_write3), .reg_dst(reg_dst3), .mem_to_reg(mem_to_reg3),
    .illegal_op(illegal_op3), .instr_retired(instr_retired3)
  );

  typedef struct packed {
    logic [3:0] aluop;
    logic       src_a;
    logic [1:0] src_b;
    logic [1:0] pc_src;
    logic       pc_en, ir_write, iord, mem_write, reg_write, reg_dst, mem_to_reg, illegal_op;
  } ctl_t;

  typedef enum int {C_LW, C_SW, C_R, C_ADDI, C_BEQ, C_BNE, C_J, C_ILL} cls_t;

  ctl_t act, exp_vec, ex_snap;
  assign act = {aluop, alu_src_a, alu_src_b, pc_src, pc_en, ir_write, iord,
                mem_write, reg_write, reg_dst, mem_to_reg, illegal_op};

  int          n_checks = 0, n_fail = 0;
  int          ill_pulses = 0;
  logic        chk_en = 1'b0;
  logic [31:0] exp_cnt = 0;

  task automatic chk(input string name, input logic [31:0] a, input logic [31:0] e);
    n_checks++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, a, e);
    end
  endtask

  function automatic ctl_t reset_vec();
    ctl_t v = '0;
    v.src_b = 2'b01;
    return v;
  endfunction

  function automatic cls_t classify(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      6'b000000: return (fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A}) ? C_R : C_ILL;
      6'b100011: return C_LW;
      6'b101011: return C_SW;
      6'b000100: return C_BEQ;
      6'b001000: return C_ADDI;
      6'b000010: return C_J;
`ifdef MC_CONTROL_BNE_EN
      6'b000101: return C_BNE;
`endif
      default:   return C_ILL;
    endcase
  endfunction

  function automatic int cycles_of(input cls_t c);
    case (c)
      C_LW: return 5;
      C_SW, C_R, C_ADDI: return 4;
      C_ILL: return 2;
      default: return 3;
    endcase
  endfunction

  // What the datapath must see on cycle k of an instruction of class c.
  function automatic ctl_t expect_ctl(input cls_t c, input int k, input logic [5:0] fn, input logic z);
    ctl_t v = '0;
    if (k == 0) begin
      v.src_b = 2'b01; v.ir_write = 1; v.pc_en = 1;
    end else if (k == 1) begin
      v.src_b = 2'b11; v.illegal_op = (c == C_ILL);
    end else begin
      case (c)
        C_LW, C_SW: begin
          if (k == 2) begin v.src_a = 1; v.src_b = 2'b10; end
          else if (c == C_SW) begin v.iord = 1; v.mem_write = 1; end
          else if (k == 3) v.iord = 1;
          else begin v.mem_to_reg = 1; v.reg_write = 1; end
        end
        C_R: begin
          if (k == 2) begin v.src_a = 1; v.aluop = fn[3:0]; end
          else begin v.reg_dst = 1; v.reg_write = 1; end
        end
        C_ADDI: begin
          if (k == 2) begin v.src_a = 1; v.src_b = 2'b10; end
          else v.reg_write = 1;
        end
        C_BEQ, C_BNE: begin
          v.src_a = 1; v.aluop = 4'b0010; v.pc_src = 2'b01;
          v.pc_en = (c == C_BEQ) ? z : ~z;
        end
        C_J: begin v.pc_src = 2'b10; v.pc_en = 1; end
        default: ;
      endcase
    end
    return v;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      chk("ctl", 32'(act), 32'(exp_vec));
      chk("instr_retired", instr_retired, exp_cnt);
      chk("instr_retired_w3", 32'(instr_retired3), 32'(exp_cnt[2:0]));
      if (illegal_op) ill_pulses++;
    end
  end

  // zmode: 0/1 force zero, 2 random. max_k limits how many cycles are run.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int zmode, input int max_k);
    cls_t c = classify(op, fn);
    int   n = cycles_of(c);
    if (max_k < n) n = max_k;
    for (int k = 0; k < n; k++) begin
      if (k == 1 || (c == C_R && k == 2)) begin
        opcode = op; funct = fn;
      end else begin
        opcode = 6'($urandom); funct = 6'($urandom);
      end
      zero = (zmode == 2) ? 1'($urandom) : zmode[0];
      exp_vec = expect_ctl(c, k, fn, zero);
      @(negedge clk); #1;
      if (k == 2) ex_snap = act;
      @(posedge clk); #1;
      if (k == cycles_of(c) - 1 && c != C_ILL) exp_cnt++;
    end
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b1;
    exp_vec = reset_vec();
    exp_cnt = 0;
    repeat (cycles) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  int ill0;
  logic [5:0] rop, rfn;
  logic [5:0] legal_fn [7] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A};

  initial begin
    exp_vec = reset_vec();
    chk_en = 1'b1;
    do_reset(2);

    // Two instructions, then a load aborted by reset in MEMRD.
    run_instr(6'b001000, 6'h00, 2, 99);
    run_instr(6'b000010, 6'h00, 2, 99);
    chk("cnt_before_abort", instr_retired, 32'd2);
    run_instr(6'b100011, 6'h00, 2, 3);
    #2;
    reset = 1'b1;
    exp_vec = reset_vec();
    exp_cnt = 0;
    #1;
    chk("rst_async_iord", 32'(iord), 32'd0);
    chk("rst_enables", 32'({pc_en, ir_write, mem_write, reg_write, illegal_op}), 32'd0);
    chk("rst_src_b", 32'(alu_src_b), 32'd1);
    chk("rst_cnt", instr_retired, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    #1;
    chk("post_rst_fetch", 32'({ir_write, pc_en}), 32'd3);

    // Directed: slt, lw, sw, beq taken / not taken.
    run_instr(6'b000000, 6'h2A, 2, 99);
    chk("slt_aluop", 32'(ex_snap.aluop), 32'd10);
    chk("cnt_after_slt", instr_retired, 32'd1);
    run_instr(6'b100011, 6'h00, 2, 99);
    run_instr(6'b101011, 6'h00, 2, 99);
    chk("cnt_after_lwsw", instr_retired, 32'd3);
    run_instr(6'b000100, 6'h00, 1, 99);
    chk("beq_taken_pc_en", 32'({ex_snap.pc_en, ex_snap.pc_src}), 32'b101);
    run_instr(6'b000100, 6'h00, 0, 99);
    chk("beq_nt_pc_en", 32'(ex_snap.pc_en), 32'd0);
    chk("cnt_after_beq", instr_retired, 32'd5);

    ill0 = ill_pulses;
    run_instr(6'b111111, 6'h00, 2, 99);
    run_instr(6'b000000, 6'h08, 2, 99);
    chk("illegal_pulses", 32'(ill_pulses - ill0), 32'd2);
    chk("cnt_after_illegal", instr_retired, 32'd5);

    ill0 = ill_pulses;
    run_instr(6'b000101, 6'h00, 0, 99);
`ifdef MC_CONTROL_BNE_EN
    chk("bne_pc_en", 32'(ex_snap.pc_en), 32'd1);
    chk("bne_cnt", instr_retired, 32'd6);
`else
    chk("bne_illegal", 32'(ill_pulses - ill0), 32'd1);
    chk("bne_cnt", instr_retired, 32'd5);
`endif

    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 9))
        0, 1: begin rop = 6'b000000; rfn = legal_fn[$urandom_range(0, 6)]; end
        2: begin rop = 6'b100011; rfn = 6'($urandom); end
        3: begin rop = 6'b101011; rfn = 6'($urandom); end
        4: begin rop = 6'b000100; rfn = 6'($urandom); end
        5: begin rop = 6'b001000; rfn = 6'($urandom); end
        6: begin rop = 6'b000010; rfn = 6'($urandom); end
        7: begin rop = 6'b000101; rfn = 6'($urandom); end
        8: begin rop = 6'($urandom); rfn = 6'($urandom); end
        default: begin rop = 6'b000000; rfn = 6'($urandom); end
      endcase
      run_instr(rop, rfn, 2, 99);
    end

    // Counter wrap on the 3-bit instance.
    #2; do_reset(1);
    for (int i = 0; i < 9; i++) run_instr(6'b001000, 6'h00, 2, 99);
    chk("wrap_w3", 32'(instr_retired3), 32'd1);
    chk("wrap_w32", instr_retired, 32'd9);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
